// File: rtl/mem_copy_dma.sv
// mem_copy_dma: memory-port initiator performing memmove-style block copy or block fill with range checking
module mem_copy_dma #(
  parameter int Bits    = 16,
  parameter int MemSize = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic [Bits-1:0] src_addr,
  input  logic [Bits-1:0] dst_addr,
  input  logic [Bits-1:0] length,
  input  logic [Bits-1:0] fill_value,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [Bits-1:0] mem_access_addr,
  output logic [Bits-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read,
  input  logic [Bits-1:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [Bits:0] LP_MEM = (Bits+1)'(MemSize);
  state_t          r_state;
  logic            r_mode, r_desc, r_busy, r_done, r_err, r_rd, r_wen;
  logic [Bits-1:0] r_src, r_dst, r_fill, r_idx, r_cnt, r_addr, r_wdata;
  logic [Bits:0]   w_src_end, w_dst_end;
  logic [Bits-1:0] w_first, w_next;
  logic            w_bad, w_desc;
  assign w_src_end = {1'b0, src_addr} + {1'b0, length};
  assign w_dst_end = {1'b0, dst_addr} + {1'b0, length};
  assign w_bad     = (w_dst_end > LP_MEM) || (!mode && (w_src_end > LP_MEM));
  // forward-overlapping copy must run high-to-low so source words are read before being overwritten
  assign w_desc    = !mode && (src_addr < dst_addr) && ({1'b0, dst_addr} < w_src_end);
  assign w_first   = w_desc ? length - Bits'(1) : '0;
  assign w_next    = r_desc ? r_idx - Bits'(1) : r_idx + Bits'(1);
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign mem_access_addr = r_addr;
  assign mem_write_data  = r_wdata;
  assign mem_write_en    = r_wen;
  assign mem_read        = r_rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_desc  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_wen   <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_fill  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      case (r_state)
        IDLE: if (start) begin
          r_mode <= mode;
          r_src  <= src_addr;
          r_dst  <= dst_addr;
          r_fill <= fill_value;
          r_desc <= w_desc;
          r_idx  <= w_first;
          r_cnt  <= length;
          if (w_bad) r_err <= 1'b1;
          else if (length == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state <= mode ? WRITE : READ;
            r_busy  <= 1'b1;
            r_addr  <= mode ? dst_addr + w_first : src_addr + w_first;
            r_wen   <= mode;
            r_rd    <= !mode;
            r_wdata <= mode ? fill_value : '0;
          end
        end
        READ: begin
          r_state <= WRITE;
          r_addr  <= r_dst + r_idx;
          r_wen   <= 1'b1;
          r_wdata <= mem_read_data;
        end
        WRITE: if (r_cnt == Bits'(1)) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_cnt   <= r_cnt - Bits'(1);
          r_idx   <= w_next;
          r_state <= r_mode ? WRITE : READ;
          r_addr  <= r_mode ? r_dst + w_next : r_src + w_next;
          r_wen   <= r_mode;
          r_rd    <= !r_mode;
          r_wdata <= r_mode ? r_fill : '0;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: scoreboard bench for mem_copy_dma with a behavioural memory
module tb_mem_copy_dma;
  localparam int K_R = 0, K_W = 1, K_D = 2, K_E = 3;
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;
  logic        clk, rst_n, start, mode;
  logic [15:0] src_addr, dst_addr, length, fill_value;
  logic        busy, done, err, mem_write_en, mem_read;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic [15:0] mem [0:255];
  ev_t         q[$];
  int          checks = 0, failures = 0, first_w = -1;
  mem_copy_dma #(.Bits(16), .MemSize(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .err(err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_access_addr[7:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[7:0]] = mem_write_data;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = 16'(addr);
    e.data = 16'(data);
    q.push_back(e);
  endtask
  task automatic chk_ev(input int kind, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d addr=%0h expected=none", kind, addr);
    end else begin
      e = q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_addr", addr, e.addr);
      chk("ev_data", data, e.data);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (mem_read && mem_write_en) chk("rd_wr_exclusive", 1, 0);
    chk("busy_vs_activity", busy, mem_read | mem_write_en | done);
    if (!mem_read && !mem_write_en) chk("idle_bus_zero", {mem_access_addr, mem_write_data}, 0);
    if (mem_read) chk_ev(K_R, mem_access_addr, 16'h0);
    if (mem_write_en) begin
      if (first_w < 0) first_w = int'(mem_access_addr);
      chk_ev(K_W, mem_access_addr, mem_write_data);
    end
    if (done) chk_ev(K_D, 16'h0, 16'h0);
    if (err) chk_ev(K_E, 16'h0, 16'h0);
  end
  // expected bus trace from memmove/fill semantics using the memory contents before the transfer
  task automatic push_model(input logic md, input int src, input int dst, input int len, input int fv);
    bit desc;
    int i;
    desc = !md && src < dst && dst < src + len;
    for (int k = 0; k < len; k++) begin
      i = desc ? len - 1 - k : k;
      if (!md) begin
        push(K_R, src + i, 0);
        push(K_W, dst + i, int'(mem[src + i]));
      end else push(K_W, dst + i, fv);
    end
    push(K_D, 0, 0);
  endtask
  task automatic do_cmd(input string nm, input logic md, input int src, input int dst, input int len,
                        input int fv, input bit exp_err, input int exp_lat, input int pulse_at);
    int k;
    if (exp_err) push(K_E, 0, 0);
    else push_model(md, src, dst, len, fv);
    @(negedge clk);
    mode = md; src_addr = 16'(src); dst_addr = 16'(dst); length = 16'(len); fill_value = 16'(fv);
    start = 1;
    @(negedge clk);
    start = 0;
    k = 1;
    while (!(done || err) && k < 200) begin
      start = (k == pulse_at);
      if (k == pulse_at) dst_addr = 16'd60;
      @(negedge clk);
      k++;
    end
    start = 0;
    chk({nm, "_latency"}, k, exp_lat);
    if (exp_err) chk({nm, "_busy_on_err"}, busy, 0);
    #1 chk({nm, "_queue_drained"}, q.size(), 0);
  endtask
  initial begin
    rst_n = 0; start = 0; mode = 0;
    src_addr = 0; dst_addr = 0; length = 0; fill_value = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 8; i++) mem[10 + i] = 16'(i + 1);
    for (int i = 0; i < 5; i++) mem[i] = 16'(10 + i);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, err, mem_read, mem_write_en}, 0);
    chk("reset_bus", {mem_access_addr, mem_write_data}, 0);
    rst_n = 1;
    do_cmd("asc_copy", 0, 10, 20, 4, 0, 0, 9, 0);
    for (int i = 0; i < 4; i++) begin
      chk("asc_dst", mem[20 + i], 16'(i + 1));
      chk("asc_src", mem[10 + i], 16'(i + 1));
    end
    first_w = -1;
    do_cmd("overlap_copy", 0, 0, 2, 5, 0, 0, 11, 0);
    chk("overlap_first_waddr", first_w, 6);
    for (int i = 0; i < 5; i++) chk("overlap_dst", mem[2 + i], 16'(10 + i));
    do_cmd("fill", 1, 0, 100, 3, 16'hBEEF, 0, 4, 0);
    for (int i = 0; i < 3; i++) chk("fill_dst", mem[100 + i], 16'hBEEF);
    mode = 1; dst_addr = 16'd200; length = 16'd1; start = 1;
    @(negedge clk);
    start = 0;
    chk("start_in_done_ignored", busy, 0);
    @(negedge clk);
    chk("start_in_done_no_write", mem[200], 16'h0);
    do_cmd("range_fill", 1, 0, 250, 10, 16'h1234, 1, 1, 0);
    chk("range_fill_nowrite", mem[250], 16'h0);
    do_cmd("range_src", 0, 250, 0, 10, 0, 1, 1, 0);
    chk("range_src_nowrite", mem[0], 16'd10);
    do_cmd("edge_ok", 1, 0, 255, 1, 16'h7777, 0, 2, 0);
    chk("edge_ok_dst", mem[255], 16'h7777);
    do_cmd("zero_len", 0, 5, 5, 0, 0, 0, 1, 0);
    do_cmd("busy_start", 0, 10, 40, 3, 0, 0, 7, 2);
    for (int i = 0; i < 3; i++) begin
      chk("busy_start_dst", mem[40 + i], 16'(i + 1));
      chk("busy_start_ignored", mem[60 + i], 16'h0);
    end
    push(K_R, 10, 0); push(K_W, 30, 1); push(K_R, 11, 0); push(K_W, 31, 2); push(K_R, 12, 0);
    @(negedge clk);
    mode = 0; src_addr = 16'd10; dst_addr = 16'd30; length = 16'd8; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_outputs", {busy, done, err, mem_read, mem_write_en}, 0);
    chk("rst_mid_bus", {mem_access_addr, mem_write_data}, 0);
    chk("rst_mid_queue", q.size(), 0);
    chk("rst_mid_w0", mem[30], 16'd1);
    chk("rst_mid_w1", mem[31], 16'd2);
    chk("rst_mid_w2_absent", mem[32], 16'h0);
    @(negedge clk);
    rst_n = 1;
    do_cmd("post_reset_fill", 1, 0, 120, 2, 16'h5A5A, 0, 3, 0);
    chk("post_reset_dst0", mem[120], 16'h5A5A);
    chk("post_reset_dst1", mem[121], 16'h5A5A);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
